vga_sync_gen: RTL



---
 rtl/vga_sync_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: registered pixel/line counters, sync/active-video decode and line/frame pulses.
// Optional macro VGA_SYNC_DELAY_EN adds one extra register stage on hsync, vsync and de only.
module vga_sync_gen #(
  parameter int unsigned SCREEN_WIDTH  = 800,
  parameter int unsigned SCREEN_HEIGHT = 600,
  parameter int unsigned H_FP          = 56,
  parameter int unsigned H_SYNC        = 120,
  parameter int unsigned H_BP          = 64,
  parameter int unsigned V_FP          = 37,
  parameter int unsigned V_SYNC        = 6,
  parameter int unsigned V_BP          = 23,
  parameter bit          SYNC_POL      = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pix_en,
  output logic [10:0] hst,
  output logic [9:0]  vst,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = SCREEN_WIDTH + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = SCREEN_HEIGHT + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048) begin : g_h_total_chk
    $error("vga_sync_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_sync_gen: V_TOTAL exceeds 1024");
  end

  // One bit wider than the counters so a window ending exactly at the total cannot wrap to 0.
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_VIS    = 12'(SCREEN_WIDTH);
  localparam logic [11:0] HS_START = 12'(SCREEN_WIDTH + H_FP);
  localparam logic [11:0] HS_END   = 12'(SCREEN_WIDTH + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_VIS    = 11'(SCREEN_HEIGHT);
  localparam logic [10:0] VS_START = 11'(SCREEN_HEIGHT + V_FP);
  localparam logic [10:0] VS_END   = 11'(SCREEN_HEIGHT + V_FP + V_SYNC);

  logic [10:0] hst_q, hst_d;
  logic [9:0]  vst_q, vst_d;
  logic        h_wrap, v_wrap;
  logic        line_start_q, frame_start_q;
  logic        hsync_q, vsync_q, de_q;
  logic        hs_d, vs_d, de_d;
  logic [11:0] hx_d;
  logic [10:0] vx_d;

  always_comb begin
    hst_d  = hst_q;
    vst_d  = vst_q;
    h_wrap = 1'b0;
    v_wrap = 1'b0;
    if (pix_en) begin
      if ({1'b0, hst_q} >= H_LAST) begin
        hst_d  = '0;
        h_wrap = 1'b1;
        if ({1'b0, vst_q} >= V_LAST) begin
          vst_d  = '0;
          v_wrap = 1'b1;
        end else begin
          vst_d = vst_q + 10'd1;
        end
      end else begin
        hst_d = hst_q + 11'd1;
      end
    end
  end

  // Decode from the next counter values so the registered flags line up with the registered counters.
  always_comb begin
    hx_d = {1'b0, hst_d};
    vx_d = {1'b0, vst_d};
    hs_d = ((hx_d >= HS_START) && (hx_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_d = ((vx_d >= VS_START) && (vx_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    de_d = (hx_d < H_VIS) && (vx_d < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hst_q         <= '0;
      vst_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hst_q         <= hst_d;
      vst_q         <= vst_d;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_p_q, vsync_p_q, de_p_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hsync_p_q <= ~SYNC_POL;
      vsync_p_q <= ~SYNC_POL;
      de_p_q    <= 1'b0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      de_q      <= 1'b0;
    end else begin
      hsync_p_q <= hs_d;
      vsync_p_q <= vs_d;
      de_p_q    <= de_d;
      hsync_q   <= hsync_p_q;
      vsync_q   <= vsync_p_q;
      de_q      <= de_p_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
    end else begin
      hsync_q <= hs_d;
      vsync_q <= vs_d;
      de_q    <= de_d;
    end
  end
`endif

  assign hst         = hst_q;
  assign vst         = vst_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
